// File: rtl/hazard_mem_controller.sv
// hazard_mem_controller
//  Hazard and sequencing control for the 5-stage RISC-V pipeline. It produces the
//  stall, flush and forwarding controls for the F/D/E/M/W pipeline registers. It
//  also runs an IDLE/WAIT handshake FSM that freezes the pipeline while a
//  multi-cycle data memory access is outstanding, bubbling MEM->WB until the data
//  returns or the access times out.
//  Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   Rs1D, Rs2D / Rs1E, Rs2E       source registers in Decode / Execute
//   RdE, RdM, RdW                 destination registers in E / M / W
//   ResultSrcE                    2'b01 marks a load in Execute
//   RegWriteM, RegWriteW          M / W instruction writes the register file
//   PCSrcE                        taken branch/jump resolved in Execute
//   MemReqM, MemReadyM            data memory request / completion
//   StallF..StallM                hold the corresponding pipeline register
//   FlushD, FlushE, FlushW        clear the corresponding pipeline register
//   ForwardAE, ForwardBE          00 RF, 10 from M, 01 from W
//   MemStartM                     one-cycle request strobe to data memory
//   MemErr                        sticky access-timeout flag
//   StallCycles                   saturating count of stalled cycles
module hazard_mem_controller #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemStartM,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              state, next_state;
    logic [WCNT_W-1:0]   wcnt, next_wcnt;
    logic                mem_stall;
    logic                lw_stall;
    logic                set_err;

    // Operand forwarding; M has priority over W, x0 is never forwarded
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
            ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
            ForwardAE = 2'b01;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
            ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
            ForwardBE = 2'b01;
    end

    // Load-use hazard: a load in E feeds an operand of the instruction in D
    always_comb begin
        lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));
    end

    // Memory wait-state FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            wcnt  <= '0;
        end else begin
            state <= next_state;
            wcnt  <= next_wcnt;
        end
    end

    // Memory wait-state FSM: next state, strobe, stall and timeout
    always_comb begin
        next_state = state;
        next_wcnt  = wcnt;
        MemStartM  = 1'b0;
        mem_stall  = 1'b0;
        set_err    = 1'b0;
        unique case (state)
            S_IDLE: begin
                MemStartM = MemReqM;
                if (MemReqM && !MemReadyM) begin
                    mem_stall  = 1'b1;
                    next_state = S_WAIT;
                    next_wcnt  = '0;
                end
            end
            S_WAIT: begin
                // The held instruction keeps MemReqM high; no re-strobe here
                if (MemReadyM) begin
                    next_state = S_IDLE;
                end else if (wcnt == WCNT_W'(MAX_WAIT)) begin
                    // Abandon the access and let the pipeline move on
                    set_err    = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    next_wcnt = wcnt + WCNT_W'(1);
                end
            end
            default: begin
                next_state = S_IDLE;
                next_wcnt  = '0;
            end
        endcase
    end

    // Pipeline controls; an outstanding memory access overrides load-use and branch
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall | PCSrcE;
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            MemErr <= 1'b0;
        else if (set_err)
            MemErr <= 1'b1;
    end

    // Saturating stall-cycle performance counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            StallCycles <= '0;
        else if ((mem_stall || lw_stall) && (StallCycles != {CNT_W{1'b1}}))
            StallCycles <= StallCycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_mem_controller.sv
// tb_hazard_mem_controller
//  Scenario bench for hazard_mem_controller. Expected control vectors are queued
//  when stimulus is applied and compared once the outputs settle. A second
//  instance with a 2-bit counter exposes StallCycles saturation.
module tb_hazard_mem_controller;

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemStartM, MemErr;
    logic [CNT_W-1:0] StallCycles;

    logic        s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_FlushW;
    logic [1:0]  s_ForwardAE, s_ForwardBE;
    logic        s_MemStartM, s_MemErr;
    logic [1:0]  s_StallCycles;

    typedef struct {
        string       name;
        logic [12:0] ctrl;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    hazard_mem_controller #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemStartM(MemStartM), .MemErr(MemErr), .StallCycles(StallCycles)
    );

    hazard_mem_controller #(.CNT_W(2), .MAX_WAIT(MAX_WAIT)) u_sat (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .StallM(s_StallM),
        .FlushD(s_FlushD), .FlushE(s_FlushE), .FlushW(s_FlushW),
        .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
        .MemStartM(s_MemStartM), .MemErr(s_MemErr), .StallCycles(s_StallCycles)
    );

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE,MemStartM,MemErr}
    function automatic logic [12:0] obs();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                ForwardAE, ForwardBE, MemStartM, MemErr};
    endfunction

    function automatic logic [12:0] mk(input logic sf, input logic sd, input logic se,
                                       input logic sm, input logic fd, input logic fe,
                                       input logic fw, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic ms,
                                       input logic me);
        return {sf, sd, se, sm, fd, fe, fw, fa, fb, ms, me};
    endfunction

    task automatic clr_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00;
        RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
        MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        clr_inputs();
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        clr_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sbq.push_back('{"reset_idle", mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0)});
        @(negedge clk);
        e = sbq.pop_front();
        tests++;
        if (obs() !== e.ctrl) begin
            fails++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.ctrl);
        end
        tests++;
        if (StallCycles !== 16'd0 || s_StallCycles !== 2'd0) begin
            fails++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", StallCycles, s_StallCycles);
        end
        // Under reset the FSM sits in IDLE, so the comb outputs follow the request
        next_cycle();
        MemReqM = 1'b1;
        sbq.push_back('{"reset_held_req", mk(1,1,1,1,0,0,1,2'b00,2'b00,1,0)});
        @(negedge clk);
        e = sbq.pop_front();
        tests++;
        if (obs() !== e.ctrl) begin
            fails++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.ctrl);
        end
        @(posedge clk);
        #1 clr_inputs();
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_forward();
        logic [4:0] r1e [6];
        logic [4:0] r2e [6];
        logic [4:0] rdm [6];
        logic [4:0] rdw [6];
        logic       rwm [6];
        logic       rww [6];
        logic [1:0] fa  [6];
        logic [1:0] fb  [6];
        r1e = '{5'd5, 5'd5, 5'd5, 5'd9, 5'd3, 5'd0};
        r2e = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd4, 5'd0};
        rdm = '{5'd5, 5'd0, 5'd0, 5'd9, 5'd3, 5'd0};
        rdw = '{5'd5, 5'd5, 5'd0, 5'd9, 5'd4, 5'd0};
        rwm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        rww = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        fa  = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
        fb  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 6; i++) begin
            clr_inputs();
            Rs1E = r1e[i]; Rs2E = r2e[i]; RdM = rdm[i]; RdW = rdw[i];
            RegWriteM = rwm[i]; RegWriteW = rww[i];
            sbq.push_back('{$sformatf("forward_%0d", i), mk(0,0,0,0,0,0,0,fa[i],fb[i],0,0)});
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if (obs() !== e.ctrl) begin
                fails++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.ctrl);
            end
            next_cycle();
        end
        clr_inputs();
    endtask

    task automatic test_load_use();
        logic [1:0] rs  [5];
        logic [4:0] rde [5];
        logic [4:0] r1d [5];
        logic [4:0] r2d [5];
        logic       stl [5];
        rs  = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b01};
        rde = '{5'd7,  5'd7,  5'd0,  5'd7,  5'd7};
        r1d = '{5'd3,  5'd3,  5'd0,  5'd7,  5'd7};
        r2d = '{5'd7,  5'd7,  5'd0,  5'd0,  5'd0};
        stl = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            clr_inputs();
            ResultSrcE = rs[i]; RdE = rde[i]; Rs1D = r1d[i]; Rs2D = r2d[i];
            sbq.push_back('{$sformatf("load_use_%0d", i),
                            mk(stl[i],stl[i],0,0,0,stl[i],0,2'b00,2'b00,0,0)});
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if (obs() !== e.ctrl) begin
                fails++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.ctrl);
            end
            if (i == 1) begin
                tests++;
                if (StallCycles !== 16'd1) begin
                    fails++;
                    $display("FAIL load_use_count1: got %0d expected 1", StallCycles);
                end
            end
            next_cycle();
        end
        clr_inputs();
        @(negedge clk);
        tests++;
        if (StallCycles !== 16'd2) begin
            fails++;
            $display("FAIL load_use_count2: got %0d expected 2", StallCycles);
        end
        next_cycle();
    endtask

    task automatic test_branch();
        clr_inputs();
        PCSrcE = 1'b1;
        sbq.push_back('{"branch_only", mk(0,0,0,0,1,1,0,2'b00,2'b00,0,0)});
        @(negedge clk);
        e = sbq.pop_front();
        tests++;
        if (obs() !== e.ctrl) begin
            fails++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.ctrl);
        end
        next_cycle();
        ResultSrcE = 2'b01; RdE = 5'd12; Rs1D = 5'd12;
        sbq.push_back('{"branch_and_load", mk(1,1,0,0,1,1,0,2'b00,2'b00,0,0)});
        @(negedge clk);
        e = sbq.pop_front();
        tests++;
        if (obs() !== e.ctrl) begin
            fails++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.ctrl);
        end
        next_cycle();
        clr_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            clr_inputs();
            MemReqM   = 1'b1;
            MemReadyM = (i == 3);
            if (i == 1) begin
                // Branch and load-use must be ignored while memory holds the pipe
                PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
            end
            if (i == 3)
                sbq.push_back('{"mem_ready", mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0)});
            else
                sbq.push_back('{$sformatf("mem_wait_%0d", i),
                                mk(1,1,1,1,0,0,1,2'b00,2'b00,(i == 0),0)});
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if (obs() !== e.ctrl) begin
                fails++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.ctrl);
            end
            next_cycle();
        end
        clr_inputs();
        @(negedge clk);
        tests++;
        if (StallCycles !== 16'd3 || s_StallCycles !== 2'd3) begin
            fails++;
            $display("FAIL mem_wait_count: got %0d/%0d expected 3/3", StallCycles, s_StallCycles);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            clr_inputs();
            MemReqM   = 1'b1;
            MemReadyM = (i != 2);
            if (i < 2)
                sbq.push_back('{$sformatf("b2b_zero_wait_%0d", i),
                                mk(0,0,0,0,0,0,0,2'b00,2'b00,1,0)});
            else if (i == 2)
                sbq.push_back('{"b2b_third_waits", mk(1,1,1,1,0,0,1,2'b00,2'b00,1,0)});
            else
                sbq.push_back('{"b2b_third_done", mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0)});
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if (obs() !== e.ctrl) begin
                fails++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.ctrl);
            end
            next_cycle();
        end
        clr_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            clr_inputs();
            MemReqM = 1'b1;
            if (i < 5)
                sbq.push_back('{$sformatf("timeout_stall_%0d", i),
                                mk(1,1,1,1,0,0,1,2'b00,2'b00,(i == 0),0)});
            else
                sbq.push_back('{"timeout_release", mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0)});
            @(negedge clk);
            e = sbq.pop_front();
            tests++;
            if (obs() !== e.ctrl) begin
                fails++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.ctrl);
            end
            next_cycle();
        end
        clr_inputs();
        repeat (3) next_cycle();
        sbq.push_back('{"timeout_sticky", mk(0,0,0,0,0,0,0,2'b00,2'b00,0,1)});
        @(negedge clk);
        e = sbq.pop_front();
        tests++;
        if (obs() !== e.ctrl) begin
            fails++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.ctrl);
        end
        tests++;
        if (StallCycles !== 16'd5 || s_StallCycles !== 2'd3) begin
            fails++;
            $display("FAIL timeout_count: got %0d/%0d expected 5/3", StallCycles, s_StallCycles);
        end
        next_cycle();
        do_reset();
        @(negedge clk);
        tests++;
        if (MemErr !== 1'b0) begin
            fails++;
            $display("FAIL timeout_err_cleared: got %b expected 0", MemErr);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        MemReqM = 1'b1;
        repeat (2) next_cycle();
        // Now in WAIT with two stalled cycles counted; reset asynchronously
        rst = 1'b1;
        #1;
        tests++;
        if (StallCycles !== 16'd0 || MemErr !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_wait_regs: got %0d/%b expected 0/0", StallCycles, MemErr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        sbq.push_back('{"rst_mid_wait_restrobe", mk(1,1,1,1,0,0,1,2'b00,2'b00,1,0)});
        e = sbq.pop_front();
        tests++;
        if (obs() !== e.ctrl) begin
            fails++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.ctrl);
        end
        next_cycle();
        sbq.push_back('{"rst_mid_wait_rewait", mk(1,1,1,1,0,0,1,2'b00,2'b00,0,0)});
        @(negedge clk);
        e = sbq.pop_front();
        tests++;
        if (obs() !== e.ctrl) begin
            fails++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.ctrl);
        end
        next_cycle();
        MemReadyM = 1'b1;
        next_cycle();
        clr_inputs();
        next_cycle();
    endtask

    initial begin
        clr_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
